// File: rtl/mu0_pkg.sv
// MU0 sequencer shared types and constants.
// Imported by the interface, the loader and the sequencer top.
package mu0_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam logic [3:0] OP_STP = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FETCH,
      S_EXEC1,
      S_EXEC2,
      S_HALT
   } state_t;

   typedef struct packed {
      logic fetch;
      logic exec1;
      logic exec2;
      logic halted;
      logic loading;
   } phase_t;

   function automatic phase_t decode(state_t s);
      phase_t p;
      p         = '0;
      p.fetch   = (s == S_FETCH);
      p.exec1   = (s == S_EXEC1);
      p.exec2   = (s == S_EXEC2);
      p.halted  = (s == S_HALT);
      p.loading = (s == S_LOAD);
      return p;
   endfunction

endpackage

// File: rtl/mu0_sequencer_if.sv
// Control, decoder-phase and UART-load signals of the MU0 sequencer.
// master drives the controls, slave is the sequencer.
interface mu0_sequencer_if;
   import mu0_pkg::*;

   logic              run;
   logic              step;
   logic              load_start;
   logic [3:0]        op;
   logic              EXTRA;
   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              FETCH;
   logic              EXEC1;
   logic              EXEC2;
   logic              halted;
   logic              loading;
   logic              uart;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;

   modport master (
      output run, step, load_start, op, EXTRA,
      output rx_valid, rx_byte,
      input  FETCH, EXEC1, EXEC2, halted, loading,
      input  uart, load_addr, load_data
   );

   modport slave (
      input  run, step, load_start, op, EXTRA,
      input  rx_valid, rx_byte,
      output FETCH, EXEC1, EXEC2, halted, loading,
      output uart, load_addr, load_data
   );

endinterface

// File: rtl/mu0_uart_loader.sv
// Pairs received bytes (high first) into words and strobes them
// into memory at an auto-incrementing address.
module mu0_uart_loader
   import mu0_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              uart,
   output logic [ADDR_W-1:0] load_addr,
   output logic [DATA_W-1:0] load_data
);

   logic [7:0] hi;
   logic       hi_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi        <= '0;
         hi_vld    <= 1'b0;
         uart      <= 1'b0;
         load_addr <= '0;
         load_data <= '0;
      end else begin
         uart <= en && rx_valid && hi_vld;
         if (clr) begin
            load_addr <= '0;
            hi_vld    <= 1'b0;
         end else begin
            // address advances once the strobe cycle has been seen
            if (uart)
               load_addr <= load_addr + ADDR_W'(1);
            if (!en) begin
               hi_vld <= 1'b0;
            end else if (rx_valid) begin
               if (hi_vld) begin
                  load_data <= {hi, rx_byte};
                  hi_vld    <= 1'b0;
               end else begin
                  hi     <= rx_byte;
                  hi_vld <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: fetch/execute phases, halt and
// UART program-load mode.
module mu0_sequencer
   import mu0_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   mu0_sequencer_if.slave  bus
);

   state_t state;
   state_t state_nx;
   logic   single;
   logic   single_nx;
   logic   instr_end;
   phase_t ph_q;
   logic   ld_en;
   logic   ld_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         single <= 1'b0;
         ph_q   <= '0;
      end else begin
         state  <= state_nx;
         single <= single_nx;
         ph_q   <= decode(state_nx);
      end
   end

   always_comb begin
      state_nx  = state;
      single_nx = single;
      instr_end = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.load_start) begin
               state_nx = S_LOAD;
            end else if (bus.step) begin
               state_nx  = S_FETCH;
               single_nx = 1'b1;
            end else if (bus.run) begin
               state_nx  = S_FETCH;
               single_nx = 1'b0;
            end
         end
         S_FETCH: state_nx = S_EXEC1;
         S_EXEC1: begin
            if (bus.op == OP_STP)
               state_nx = S_HALT;
            else if (bus.EXTRA)
               state_nx = S_EXEC2;
            else
               instr_end = 1'b1;
         end
         S_EXEC2: instr_end = 1'b1;
         S_HALT: begin
            if (bus.load_start)
               state_nx = S_LOAD;
         end
         S_LOAD: begin
            if (!bus.load_start)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // a stepped instruction always returns to IDLE
      if (instr_end) begin
         if (single || !bus.run) begin
            state_nx  = S_IDLE;
            single_nx = 1'b0;
         end else begin
            state_nx = S_FETCH;
         end
      end
   end

   assign ld_en  = (state == S_LOAD) && bus.load_start;
   assign ld_clr = (state_nx == S_LOAD) && (state != S_LOAD);

   mu0_uart_loader u_loader (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (ld_en),
      .clr       (ld_clr),
      .rx_valid  (bus.rx_valid),
      .rx_byte   (bus.rx_byte),
      .uart      (bus.uart),
      .load_addr (bus.load_addr),
      .load_data (bus.load_data)
   );

   assign bus.FETCH   = ph_q.fetch;
   assign bus.EXEC1   = ph_q.exec1;
   assign bus.EXEC2   = ph_q.exec2;
   assign bus.halted  = ph_q.halted;
   assign bus.loading = ph_q.loading;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Scoreboard bench for mu0_sequencer: phase strobes and load writes
// are checked against queued expectations stamped with their cycle.
module tb_mu0_sequencer;
   import mu0_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mu0_sequencer_if bus ();

   mu0_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] ph;
   } ph_e;

   typedef struct {
      int          cyc;
      logic [11:0] a;
      logic [15:0] d;
   } wr_e;

   ph_e phq[$];
   wr_e wq[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic exp_ph(int c, logic [1:0] p);
      ph_e e;
      e.cyc = c;
      e.ph = p;
      phq.push_back(e);
   endtask

   task automatic exp_wr(int c, logic [11:0] a, logic [15:0] d);
      wr_e e;
      e.cyc = c;
      e.a = a;
      e.d = d;
      wq.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx(logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte = b;
      tick(1);
      bus.rx_valid = 1'b0;
   endtask

   task automatic word(logic [11:0] a, logic [15:0] d);
      rx(d[15:8]);
      bus.rx_valid = 1'b1;
      bus.rx_byte = d[7:0];
      exp_wr(cyc + 1, a, d);
      tick(1);
      bus.rx_valid = 1'b0;
   endtask

   function automatic logic [15:0] wdat(int i);
      logic [15:0] v;
      v = 16'(i);
      return {v[7:0] ^ 8'hA5, v[15:8] + 8'h3C};
   endfunction

   // monitor
   logic [1:0] mon_p;
   ph_e mon_pe;
   wr_e mon_we;
   always @(negedge clk) begin
      mon_p = bus.FETCH ? 2'd1 : bus.EXEC1 ? 2'd2 : bus.EXEC2 ? 2'd3 : 2'd0;
      if (mon_p != 2'd0 || bus.uart)
         chk("onehot", $countones({bus.FETCH, bus.EXEC1, bus.EXEC2, bus.uart}), 1);
      if (mon_p != 2'd0) begin
         if (phq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_phase: got %0d want none (cyc %0d)", mon_p, cyc);
         end else begin
            mon_pe = phq.pop_front();
            chk("phase_cyc", cyc, mon_pe.cyc);
            chk("phase_code", 32'(mon_p), 32'(mon_pe.ph));
         end
      end
      if (bus.uart) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_uart: addr %0h data %0h (cyc %0d)",
                     bus.load_addr, bus.load_data, cyc);
         end else begin
            mon_we = wq.pop_front();
            chk("uart_cyc", cyc, mon_we.cyc);
            chk("uart_addr", 32'(bus.load_addr), 32'(mon_we.a));
            chk("uart_data", 32'(bus.load_data), 32'(mon_we.d));
         end
      end
   end

   int c;

   initial begin
      bus.run = 0;
      bus.step = 0;
      bus.load_start = 0;
      bus.op = 4'h0;
      bus.EXTRA = 0;
      bus.rx_valid = 0;
      bus.rx_byte = 8'h00;
      tick(2);
      chk("reset_ctl", {bus.FETCH, bus.EXEC1, bus.EXEC2,
                        bus.halted, bus.loading, bus.uart}, 0);
      chk("reset_addr", 32'(bus.load_addr), 0);
      chk("reset_data", 32'(bus.load_data), 0);
      rst_n = 1'b1;
      tick(1);

      // run with EXTRA: back-to-back 3-cycle instructions
      bus.op = 4'h0;
      bus.EXTRA = 1;
      c = cyc;
      for (int k = 0; k < 3; k++) begin
         exp_ph(c + 1 + 3 * k, 2'd1);
         exp_ph(c + 2 + 3 * k, 2'd2);
         exp_ph(c + 3 + 3 * k, 2'd3);
      end
      bus.run = 1;
      tick(9);
      bus.run = 0;
      tick(3);
      chk("a_idle", {bus.FETCH, bus.EXEC1, bus.EXEC2}, 0);

      // run without EXTRA, drop run during EXEC1
      bus.op = 4'b0100;
      bus.EXTRA = 0;
      c = cyc;
      exp_ph(c + 1, 2'd1);
      exp_ph(c + 2, 2'd2);
      exp_ph(c + 3, 2'd1);
      exp_ph(c + 4, 2'd2);
      bus.run = 1;
      tick(4);
      bus.run = 0;
      tick(1);
      chk("b_idle_next", {bus.FETCH, bus.EXEC1, bus.EXEC2,
                          bus.halted, bus.loading}, 0);
      tick(2);

      // single step with EXTRA
      bus.op = 4'h0;
      bus.EXTRA = 1;
      c = cyc;
      exp_ph(c + 1, 2'd1);
      exp_ph(c + 2, 2'd2);
      exp_ph(c + 3, 2'd3);
      bus.step = 1;
      tick(1);
      bus.step = 0;
      tick(4);
      chk("c_idle", {bus.FETCH, bus.EXEC1, bus.EXEC2}, 0);

      // step together with run: one instruction, IDLE, then run resumes
      bus.op = 4'b0100;
      bus.EXTRA = 0;
      c = cyc;
      exp_ph(c + 1, 2'd1);
      exp_ph(c + 2, 2'd2);
      exp_ph(c + 4, 2'd1);
      exp_ph(c + 5, 2'd2);
      exp_ph(c + 6, 2'd1);
      exp_ph(c + 7, 2'd2);
      bus.run = 1;
      bus.step = 1;
      tick(1);
      bus.step = 0;
      tick(6);
      bus.run = 0;
      tick(2);

      // STP halts; run/step ignored; load_start leaves
      bus.op = OP_STP;
      bus.EXTRA = 0;
      c = cyc;
      exp_ph(c + 1, 2'd1);
      exp_ph(c + 2, 2'd2);
      bus.run = 1;
      tick(3);
      chk("d_halted", 32'(bus.halted), 1);
      bus.run = 0;
      bus.step = 1;
      tick(1);
      bus.step = 0;
      bus.run = 1;
      tick(2);
      bus.step = 1;
      tick(1);
      bus.step = 0;
      bus.run = 0;
      tick(1);
      chk("d_still_halt", {bus.halted, bus.FETCH, bus.EXEC1,
                           bus.EXEC2, bus.loading}, 5'b10000);
      bus.op = 4'h0;
      bus.load_start = 1;
      tick(1);
      chk("d_load", {bus.halted, bus.loading}, 2'b01);

      // two words
      chk("e_addr0", 32'(bus.load_addr), 0);
      word(12'd0, 16'h1234);
      word(12'd1, 16'hABCD);
      tick(2);
      chk("e_addr2", 32'(bus.load_addr), 2);

      // odd byte, then leave LOAD with a byte in the same cycle
      rx(8'h77);
      bus.load_start = 0;
      bus.rx_valid = 1;
      bus.rx_byte = 8'h88;
      tick(1);
      bus.rx_valid = 0;
      tick(1);
      chk("f_left_load", 32'(bus.loading), 0);
      rx(8'h01);
      rx(8'h02);
      tick(2);
      chk("f_addr_hold", 32'(bus.load_addr), 2);
      bus.load_start = 1;
      tick(1);
      chk("f_reload", 32'(bus.loading), 1);
      chk("f_reload_addr", 32'(bus.load_addr), 0);

      // 8192 words total: address wraps back to 0
      word(12'd0, 16'h9911);
      for (int i = 1; i < 4095; i++) word(12'(i), wdat(i));
      tick(2);
      chk("g_addr4095", 32'(bus.load_addr), 4095);
      for (int i = 4095; i < 8192; i++) word(12'(i), wdat(i));
      tick(2);
      chk("g_wrap", 32'(bus.load_addr), 0);
      chk("g_last_data", 32'(bus.load_data), 32'(16'h5A5B));

      // reset in the middle of a pair
      rx(8'h55);
      rst_n = 1'b0;
      #1;
      chk("h_rst_ctl", {bus.FETCH, bus.EXEC1, bus.EXEC2,
                        bus.halted, bus.loading, bus.uart}, 0);
      chk("h_rst_addr", 32'(bus.load_addr), 0);
      chk("h_rst_data", 32'(bus.load_data), 0);
      bus.load_start = 0;
      @(negedge clk);
      rst_n = 1'b1;
      rx(8'h66);
      tick(1);
      bus.op = 4'b0100;
      bus.EXTRA = 0;
      c = cyc;
      exp_ph(c + 1, 2'd1);
      exp_ph(c + 2, 2'd2);
      bus.step = 1;
      tick(1);
      bus.step = 0;
      tick(4);
      chk("h_idle", {bus.FETCH, bus.EXEC1, bus.EXEC2,
                     bus.halted, bus.loading, bus.uart}, 0);

      chk("ph_drained", 32'(phq.size()), 0);
      chk("wr_drained", 32'(wq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mu0_sequencer.md
MU0_SEQUENCER -- requirements
Module: mu0_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 run  input  1  level; 1 = execute instructions continuously.
REQ-004 step  input  1  single-cycle pulse; executes exactly one instruction from IDLE.
REQ-005 load_start  input  1  level; 1 = enter or stay in program-load mode.
REQ-006 op  input  4  opcode field from the instruction register.
REQ-007 EXTRA  input  1  from decoder; 1 = the instruction needs EXEC2.
REQ-008 rx_valid  input  1  one-cycle strobe; rx_byte is valid.
REQ-009 rx_byte  input  8  received UART byte.
REQ-010 FETCH, EXEC1, EXEC2  output  1 each  phase strobes to the decoder; one-hot or all zero.
REQ-011 halted  output  1  in HALT state.
REQ-012 loading  output  1  in LOAD state.
REQ-013 uart  output  1  one-cycle memory write strobe during load.
REQ-014 load_addr  output  12  word address for the load write.
REQ-015 load_data  output  16  assembled word for the load write.

Function
REQ-016 States: IDLE, LOAD, FETCH, EXEC1, EXEC2, HALT; the phase outputs are registered decodes of the state.
REQ-017 IDLE: load_start=1 -> LOAD (highest priority); else run=1 or step=1 -> FETCH; else stay in IDLE.
REQ-018 Taking step in IDLE sets an internal single flag; taking run (step=0) clears it.
REQ-019 FETCH -> EXEC1 unconditionally, 1 cycle.
REQ-020 EXEC1: op=4'b0111 (STP) -> HALT; else EXTRA=1 -> EXEC2; else the instruction ends.
REQ-021 EXEC2 always ends the instruction, 1 cycle.
REQ-022 At instruction end: single=1 or run=0 -> IDLE with single cleared; else -> FETCH.
REQ-023 Instruction latency: 2 cycles without EXTRA, 3 cycles with EXTRA; back-to-back with no bubble while run=1.
REQ-024 HALT: held until load_start=1 (-> LOAD); run and step are ignored in HALT.
REQ-025 LOAD: bytes are paired high byte first; the second byte of a pair drives load_data={hi,lo} and pulses uart for 1 cycle, 1 cycle after its rx_valid.
REQ-026 load_addr holds during the uart pulse and increments by 1 on the cycle after it; it wraps 4095 -> 0.
REQ-027 load_addr clears to 0 on every entry into LOAD.
REQ-028 LOAD with load_start=0 -> IDLE; a pending unpaired high byte is discarded, and an rx_valid in that same cycle is ignored.
REQ-029 rx_valid outside LOAD is ignored, and no uart pulse is generated.
REQ-030 uart is never asserted in the same cycle as FETCH, EXEC1 or EXEC2.

Reset
REQ-031 rst_n=0 immediately forces IDLE, clears single and the byte-pair flag, and sets all outputs to 0, including load_addr and load_data.
REQ-032 Reset mid-instruction or mid-load aborts the instruction or load with no further uart pulse; operation resumes from IDLE after release.

Structure
REQ-033 Shared package mu0_pkg holds the state enumeration, OP_STP=4'b0111, ADDR_W=12 and DATA_W=16.
REQ-034 Byte pairing, the address counter and the uart strobe live in a sub-module mu0_uart_loader, enabled by the LOAD state.

Verification
REQ-035 Reset, then run=1 with op=0000, EXTRA=1 -> phases repeat FETCH,EXEC1,EXEC2 as 3-cycle instructions with no gaps.
REQ-036 run=1, op=0100, EXTRA=0 -> FETCH,EXEC1 repeat; drop run during EXEC1 -> IDLE next cycle.
REQ-037 In IDLE, pulse step with EXTRA=1 -> exactly one FETCH,EXEC1,EXEC2, then IDLE.
REQ-038 run=1, op=0111 in EXEC1 -> HALT with halted=1; pulsing run or step has no effect; load_start=1 -> LOAD.
REQ-039 load_start=1, bytes 0x12,0x34,0xAB,0xCD -> uart pulses with (addr 0, 0x1234) then (addr 1, 0xABCD); load_addr=2 afterwards.
REQ-040 Load 8192 words -> load_addr wraps to 0; send one odd byte, then drop load_start -> no uart pulse; assert rst_n=0 mid-pair -> IDLE and outputs all 0.
